lvt_reg_file: RTL and testbench



---
 rtl/lvt_reg_file.sv | 175 +++++++++++++++++
 tb/tb_lvt_reg_file.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_reg_file.sv
// lvt_reg_file: multi-ported physical register file on a single clock.
// Each write port owns a bank, replicated once per read port so every read
// port has a private copy. A live-value table (LVT) records which bank holds
// the newest value of each register. Reads are registered, bypass same-cycle
// writes (write-first), and a sweep after reset zeroes every register.
module lvt_reg_file #(
    parameter  int NUM_PR = 64,
    parameter  int WIDTH  = 32,
    parameter  int NUM_WR = 4,
    parameter  int NUM_RD = 8,
    localparam int AW     = $clog2(NUM_PR),
    localparam int LW     = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [NUM_WR-1:0]              wr_valid,
    input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
    input  logic [NUM_WR-1:0][WIDTH-1:0]   wr_data,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
    output logic                           init_busy
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                        state_q, state_d;
    logic [AW-1:0]                 cnt_q, cnt_d;
    logic [NUM_RD-1:0][WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                          run;

    // Live-value table: for each register, the index of the bank holding it.
    logic [LW-1:0]                 lvt_q [NUM_PR];
    logic [LW-1:0]                 lvt_d [NUM_PR];

    // Storage: bank per write port, one copy per read port.
    logic [WIDTH-1:0]              mem_q [NUM_WR][NUM_RD][NUM_PR];

    // Per-bank write controls after conflict resolution and sweep muxing.
    logic [NUM_WR-1:0]             wr_commit;
    logic [NUM_WR-1:0]             bank_we;
    logic [NUM_WR-1:0][AW-1:0]     bank_addr;
    logic [NUM_WR-1:0][WIDTH-1:0]  bank_wdata;

    // Sweep sequencer: walk cnt over every register, then enter RUN.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        run       = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_busy = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == AW'(NUM_PR - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
        endcase
    end

    // Conflict resolution: a write survives only if it is in RUN, targets a
    // non-zero register, and no higher-index valid port hits the same address.
    always_comb begin
        wr_commit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_commit[w] = run && wr_valid[w] && (wr_addr[w] != '0);
            for (int j = w + 1; j < NUM_WR; j++) begin
                if (wr_valid[j] && (wr_addr[j] == wr_addr[w])) begin
                    wr_commit[w] = 1'b0;
                end
            end
        end
    end

    // Bank write controls: the sweep borrows bank 0 to write zeros at cnt;
    // otherwise each bank follows its own write port.
    always_comb begin
        bank_we    = '0;
        bank_addr  = wr_addr;
        bank_wdata = wr_data;
        if (!run) begin
            bank_we[0]    = 1'b1;
            bank_addr[0]  = cnt_q;
            bank_wdata[0] = '0;
        end else begin
            bank_we = wr_commit;
        end
    end

    // LVT next value: sweep points every register at bank 0; in RUN each
    // surviving write points its register at its own bank.
    always_comb begin
        lvt_d = lvt_q;
        if (!run) begin
            lvt_d[cnt_q] = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_commit[w]) begin
                    lvt_d[wr_addr[w]] = LW'(w);
                end
            end
        end
    end

    // LVT register; contents are established by the sweep, not by reset.
    // NOTE: storage arrays (LVT and banks) sit outside the reset domain; the
    // post-reset sweep clears them, which avoids a reset fan-out to every bit.
    always_ff @(posedge clk) begin
        lvt_q <= lvt_d;
    end

    // Bank storage: write port w updates every read-port copy of bank w.
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WR; w++) begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (bank_we[w]) begin
                    mem_q[w][r][bank_addr[w]] <= bank_wdata[w];
                end
            end
        end
    end

    // Read path: LVT-selected bank value, then the same-cycle bypass as the
    // final stage in front of the output flops. Stall holds, INIT forces 0.
    always_comb begin
        rd_data_d = rd_data_q;
        for (int r = 0; r < NUM_RD; r++) begin
            if (!run) begin
                rd_data_d[r] = '0;
            end else if (!stall) begin
                rd_data_d[r] = '0;
                if (rd_addr[r] != '0) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (lvt_q[rd_addr[r]] == LW'(w)) begin
                            rd_data_d[r] = mem_q[w][r][rd_addr[r]];
                        end
                    end
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (wr_commit[w] && (wr_addr[w] == rd_addr[r])) begin
                            rd_data_d[r] = wr_data[w];
                        end
                    end
                end
            end
        end
    end

    // Control and output registers with asynchronous reset into INIT.
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_lvt_reg_file.sv
// tb_lvt_reg_file: self-checking bench for lvt_reg_file. Drives a default
// configuration (64 regs, 4 write, 8 read) and a small corner configuration
// (16 regs, 1 write, 2 read) from the same clock and reset.
module tb_lvt_reg_file;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default configuration signals.
    logic             d_stall;
    logic [3:0]       d_wv;
    logic [3:0][5:0]  d_wa;
    logic [3:0][31:0] d_wd;
    logic [7:0][5:0]  d_ra;
    logic [7:0][31:0] d_rd;
    logic             d_busy;

    // Corner configuration signals.
    logic             c_stall;
    logic [0:0]       c_wv;
    logic [0:0][3:0]  c_wa;
    logic [0:0][31:0] c_wd;
    logic [1:0][3:0]  c_ra;
    logic [1:0][31:0] c_rd;
    logic             c_busy;

    lvt_reg_file #(.NUM_PR(64), .WIDTH(32), .NUM_WR(4), .NUM_RD(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (d_stall),
        .wr_valid  (d_wv),
        .wr_addr   (d_wa),
        .wr_data   (d_wd),
        .rd_addr   (d_ra),
        .rd_data   (d_rd),
        .init_busy (d_busy)
    );

    lvt_reg_file #(.NUM_PR(16), .WIDTH(32), .NUM_WR(1), .NUM_RD(2)) u_dut_small (
        .clk       (clk),
        .reset     (reset),
        .stall     (c_stall),
        .wr_valid  (c_wv),
        .wr_addr   (c_wa),
        .wr_data   (c_wd),
        .rd_addr   (c_ra),
        .rd_data   (c_rd),
        .init_busy (c_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One table row: inputs for a cycle and the read data expected after it.
    typedef struct packed {
        logic [3:0]       wv;
        logic [3:0][5:0]  wa;
        logic [3:0][31:0] wd;
        logic [7:0][5:0]  ra;
        logic             st;
        logic [7:0][31:0] ex;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    task automatic v_new();
        cur = '0;
    endtask
    task automatic v_wr(input int p, input int a, input logic [31:0] d);
        cur.wv[p] = 1'b1;
        cur.wa[p] = 6'(a);
        cur.wd[p] = d;
    endtask
    task automatic v_rd(input int p, input int a, input logic [31:0] e);
        cur.ra[p] = 6'(a);
        cur.ex[p] = e;
    endtask
    task automatic v_rd_all(input int a, input logic [31:0] e);
        for (int p = 0; p < 8; p++) v_rd(p, a, e);
    endtask
    task automatic v_push();
        vecs.push_back(cur);
    endtask

    // Sweep after reset release: counts edges until init_busy falls on each
    // instance; optionally pokes writes during INIT that must be ignored.
    task automatic run_sweep(input bit poke, input string tag);
        int dn = 0;
        int cn = 0;
        if (poke) begin
            d_wv = 4'hF;
            d_wa = {6'd4, 6'd3, 6'd2, 6'd1};
            d_wd = {32'hBAD4, 32'hBAD3, 32'hBAD2, 32'hBAD1};
            c_wv = 1'b1;
            c_wa[0] = 4'd1;
            c_wd[0] = 32'hC1C1;
        end
        for (int n = 1; n <= 200 && (dn == 0 || cn == 0); n++) begin
            step();
            if (dn == 0 && !d_busy) begin
                dn = n;
                d_wv = '0;
            end
            if (cn == 0 && !c_busy) begin
                cn = n;
                c_wv = '0;
            end
        end
        d_wv = '0;
        c_wv = '0;
        check({tag, "_sweep_edges_big"}, dn, 64);
        check({tag, "_sweep_edges_small"}, cn, 16);
    endtask

    // Read every register on both instances and require zero.
    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < 8; r++) d_ra[r] = 6'(i * 8 + r);
            for (int r = 0; r < 2; r++) c_ra[r] = 4'(i * 2 + r);
            step();
            for (int r = 0; r < 8; r++)
                check($sformatf("%s_big_p%0d", tag, i * 8 + r), d_rd[r], 32'h0);
            for (int r = 0; r < 2; r++)
                check($sformatf("%s_small_p%0d", tag, i * 2 + r), c_rd[r], 32'h0);
        end
    endtask

    // Reference model storage for the random phase.
    logic [31:0] dm [64];
    logic [31:0] cm [16];
    logic [31:0] dexp [8];
    logic [31:0] cexp [2];
    logic [31:0] held [8];
    int          held_addr [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        d_stall = 1'b0; d_wv = '0; d_wa = '0; d_wd = '0; d_ra = '0;
        c_stall = 1'b0; c_wv = '0; c_wa = '0; c_wd = '0; c_ra = '0;

        // ---- reset values ----
        #12;
        check("reset_busy_big", d_busy, 1'b1);
        check("reset_busy_small", c_busy, 1'b1);
        check("reset_rd0_big", d_rd[0], 32'h0);
        check("reset_rd7_big", d_rd[7], 32'h0);
        check("reset_rd1_small", c_rd[1], 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- first sweep with writes poked during INIT ----
        run_sweep(1'b1, "first");
        read_all_zero("after_first");

        // ---- directed table ----
        held      = '{32'hA5A5_0001, 32'h2, 32'h3, 32'h4, 32'h44, 32'hDEAD, 32'hA5A5_0001, 32'h2};
        held_addr = '{5, 6, 7, 8, 9, 10, 5, 6};

        v_new(); v_wr(0, 5, 32'hA5A5_0001); v_wr(1, 6, 32'h2); v_wr(2, 7, 32'h3); v_wr(3, 8, 32'h4);
        v_push();
        v_new(); for (int p = 0; p < 8; p++) v_rd(p, held_addr[p % 4], held[p % 4]); v_push();
        v_new(); v_wr(1, 9, 32'h11); v_wr(3, 9, 32'h33); v_rd(0, 9, 32'h33); v_push();
        v_new(); v_rd_all(9, 32'h33); v_push();
        v_new(); v_wr(0, 9, 32'h44); v_push();
        v_new(); v_rd_all(9, 32'h44); v_push();
        v_new(); v_wr(2, 10, 32'hDEAD); v_rd_all(5, 32'hA5A5_0001); v_rd(3, 10, 32'hDEAD); v_push();
        v_new(); v_wr(0, 0, 32'hFFFF); v_push();
        v_new(); v_push();
        v_new(); for (int p = 0; p < 8; p++) v_rd(p, held_addr[p], held[p]); v_push();
        for (int k = 0; k < 3; k++) begin
            v_new();
            cur.st = 1'b1;
            if (k == 0) v_wr(1, 11, 32'h77);
            for (int p = 0; p < 8; p++) v_rd(p, 11, held[p]);
            v_push();
        end
        v_new(); v_rd_all(11, 32'h77); v_push();
        v_new(); for (int p = 0; p < 4; p++) v_wr(p, 12, 32'h100 + p); v_rd(7, 12, 32'h103); v_push();
        v_new(); v_rd_all(12, 32'h103); v_push();
        v_new(); v_wr(0, 14, 32'h55); v_wr(3, 0, 32'h66); v_rd_all(14, 32'h55); v_push();
        v_new();
        v_rd(0, 14, 32'h55); v_rd(1, 12, 32'h103); v_rd(2, 11, 32'h77); v_rd(3, 9, 32'h44);
        v_rd(4, 5, 32'hA5A5_0001); v_rd(5, 0, 32'h0); v_rd(6, 10, 32'hDEAD); v_rd(7, 8, 32'h4);
        v_push();

        foreach (vecs[i]) begin
            d_wv    = vecs[i].wv;
            d_wa    = vecs[i].wa;
            d_wd    = vecs[i].wd;
            d_ra    = vecs[i].ra;
            d_stall = vecs[i].st;
            step();
            for (int r = 0; r < 8; r++)
                check($sformatf("vec%0d_rd%0d", i, r), d_rd[r], vecs[i].ex[r]);
        end
        d_wv = '0; d_stall = 1'b0;

        // ---- reset in RUN: outputs clear before any edge ----
        #2;
        reset = 1'b1;
        #1;
        check("run_reset_async_rd0", d_rd[0], 32'h0);
        check("run_reset_async_rd6", d_rd[6], 32'h0);
        check("run_reset_busy", d_busy, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- reset mid-sweep at cnt = 20 ----
        repeat (20) step();
        check("mid_sweep_busy_before", d_busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_sweep_reset_rd0", d_rd[0], 32'h0);
        check("mid_sweep_reset_busy_small", c_busy, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_sweep(1'b1, "restart");
        read_all_zero("after_restart");

        // ---- random stream against the reference model ----
        for (int i = 0; i < 64; i++) dm[i] = '0;
        for (int i = 0; i < 16; i++) cm[i] = '0;
        for (int r = 0; r < 8; r++) dexp[r] = '0;
        for (int r = 0; r < 2; r++) cexp[r] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            d_stall = ($urandom_range(0, 7) == 0);
            c_stall = ($urandom_range(0, 7) == 0);
            for (int w = 0; w < 4; w++) begin
                d_wv[w] = 1'($urandom_range(0, 1));
                d_wa[w] = 6'($urandom_range(0, 15));
                d_wd[w] = $urandom;
            end
            for (int r = 0; r < 8; r++) d_ra[r] = 6'($urandom_range(0, 15));
            c_wv[0] = 1'($urandom_range(0, 1));
            c_wa[0] = 4'($urandom_range(0, 15));
            c_wd[0] = $urandom;
            for (int r = 0; r < 2; r++) c_ra[r] = 4'($urandom_range(0, 15));

            // Writes land this cycle in port order (last port wins); p0 stays 0.
            for (int w = 0; w < 4; w++)
                if (d_wv[w] && d_wa[w] != 0) dm[d_wa[w]] = d_wd[w];
            if (c_wv[0] && c_wa[0] != 0) cm[c_wa[0]] = c_wd[0];
            if (!d_stall)
                for (int r = 0; r < 8; r++) dexp[r] = (d_ra[r] == 0) ? 32'h0 : dm[d_ra[r]];
            if (!c_stall)
                for (int r = 0; r < 2; r++) cexp[r] = (c_ra[r] == 0) ? 32'h0 : cm[c_ra[r]];

            step();
            for (int r = 0; r < 8; r++)
                check($sformatf("rand%0d_big_rd%0d", cyc, r), d_rd[r], dexp[r]);
            for (int r = 0; r < 2; r++)
                check($sformatf("rand%0d_small_rd%0d", cyc, r), c_rd[r], cexp[r]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
